// File: rtl/ffo_iter.sv
// Sequential find-first-one iterator: loads a vector and emits the index of each
// set bit (or clear bit in find-zero mode) in priority order, one beat per handshake.
module ffo_iter #(
  parameter int unsigned WID       = 64,
  parameter bit          LSB_FIRST = 1'b0,
  localparam int unsigned OW       = $clog2(WID) + 1,
  localparam logic [OW-1:0] NONE   = {OW{1'b1}}
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld,
  input  logic [WID-1:0] din,
  input  logic           mode,
  input  logic           abort,
  output logic           busy,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [OW-1:0]  o_idx,
  output logic           o_last,
  output logic           o_none,
  output logic [OW-1:0]  cnt
);

  typedef enum logic [1:0] {IDLE, EMIT, EMPTY} state_t;

  state_t         state;
  logic [WID-1:0] vec;
  logic [WID-1:0] ld_vec;
  logic [WID-1:0] vec_clr;

  // Priority encoder; later loop hits overwrite earlier ones, so loop order sets the winner.
  function automatic logic [OW-1:0] enc(input logic [WID-1:0] v);
    logic [OW-1:0] r;
    r = NONE;
    if (LSB_FIRST) begin
      for (int i = int'(WID) - 1; i >= 0; i--) begin
        if (v[i]) r = OW'(i);
      end
    end else begin
      for (int i = 0; i < int'(WID); i++) begin
        if (v[i]) r = OW'(i);
      end
    end
    return r;
  endfunction

  function automatic logic one_hot(input logic [WID-1:0] v);
    return (v != '0) && ((v & (v - WID'(1))) == '0);
  endfunction

  function automatic logic [WID-1:0] clr_bit(input logic [WID-1:0] v, input logic [OW-1:0] idx);
    logic [WID-1:0] r;
    r = v;
    for (int i = 0; i < int'(WID); i++) begin
      if (OW'(i) == idx) r[i] = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    ld_vec  = mode ? ~din : din;
    vec_clr = clr_bit(vec, o_idx);
  end

  // FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_none  <= 1'b0;
      o_idx   <= NONE;
    end else if (abort) begin
      state   <= IDLE;
      vec     <= '0;
      busy    <= 1'b0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_none  <= 1'b0;
      o_idx   <= NONE;
    end else begin
      case (state)
        IDLE: begin
          if (ld) begin
            vec     <= ld_vec;
            cnt     <= '0;
            busy    <= 1'b1;
            o_valid <= 1'b1;
            o_idx   <= enc(ld_vec);
            if (ld_vec != '0) begin
              state  <= EMIT;
              o_last <= one_hot(ld_vec);
              o_none <= 1'b0;
            end else begin
              state  <= EMPTY;
              o_last <= 1'b1;
              o_none <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (o_ready) begin
            cnt    <= cnt + OW'(1);
            vec    <= vec_clr;
            o_idx  <= enc(vec_clr);
            o_last <= one_hot(vec_clr);
            if (o_last) begin
              state   <= IDLE;
              busy    <= 1'b0;
              o_valid <= 1'b0;
              o_last  <= 1'b0;
            end
          end
        end
        EMPTY: begin
          if (o_ready) begin
            cnt     <= OW'(1);
            state   <= IDLE;
            busy    <= 1'b0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_none  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffo_iter.sv
// Self-checking bench for ffo_iter: 64-bit MSB-first and 48-bit LSB-first instances
// compared against a queue-based model of the expected beat sequence.
module tb_ffo_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ld = 1'b0, mode = 1'b0, abort = 1'b0, o_ready = 1'b0, sel = 1'b0;
  logic [63:0] din = '0;

  logic       busy64, valid64, last64, none64;
  logic [6:0] idx64, cnt64;
  logic       busy48, valid48, last48, none48;
  logic [6:0] idx48, cnt48;

  logic       obs_busy, obs_valid, obs_last, obs_none;
  logic [6:0] obs_idx, obs_cnt;

  int n_chk = 0;
  int n_fail = 0;

  ffo_iter #(.WID(64), .LSB_FIRST(1'b0)) u64 (
    .clk(clk), .rst_n(rst_n), .ld(ld & ~sel), .din(din), .mode(mode), .abort(abort),
    .busy(busy64), .o_valid(valid64), .o_ready(o_ready), .o_idx(idx64),
    .o_last(last64), .o_none(none64), .cnt(cnt64)
  );

  ffo_iter #(.WID(48), .LSB_FIRST(1'b1)) u48 (
    .clk(clk), .rst_n(rst_n), .ld(ld & sel), .din(din[47:0]), .mode(mode), .abort(abort),
    .busy(busy48), .o_valid(valid48), .o_ready(o_ready), .o_idx(idx48),
    .o_last(last48), .o_none(none48), .cnt(cnt48)
  );

  always_comb begin
    obs_busy  = sel ? busy48  : busy64;
    obs_valid = sel ? valid48 : valid64;
    obs_last  = sel ? last48  : last64;
    obs_none  = sel ? none48  : none64;
    obs_idx   = sel ? idx48   : idx64;
    obs_cnt   = sel ? cnt48   : cnt64;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int exp_cnt);
    chk({tag, ".busy"},  64'(obs_busy),  64'd0);
    chk({tag, ".valid"}, 64'(obs_valid), 64'd0);
    chk({tag, ".last"},  64'(obs_last),  64'd0);
    chk({tag, ".none"},  64'(obs_none),  64'd0);
    chk({tag, ".idx"},   64'(obs_idx),   64'd127);
    chk({tag, ".cnt"},   64'(obs_cnt),   64'(exp_cnt));
  endtask

  // Load one vector, walk every beat against the model, then check the idle state.
  task automatic run_scan(input bit s, input logic [63:0] d, input bit m,
                          input int stall_beat, input int stall_len,
                          input bit rnd, input bit junk);
    int          w;
    logic [63:0] eff;
    int          q[$];
    bit          empty;
    int          acc, beat, stall, guard;
    bit          r;
    w   = s ? 48 : 64;
    eff = m ? ~d : d;
    if (w == 48) eff[63:48] = '0;
    if (s) begin
      for (int i = 0; i < w; i++) if (eff[i]) q.push_back(i);
    end else begin
      for (int i = w - 1; i >= 0; i--) if (eff[i]) q.push_back(i);
    end
    empty = (q.size() == 0);
    if (empty) q.push_back(127);

    @(negedge clk);
    sel = s; ld = 1'b1; din = d; mode = m; o_ready = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    acc = 0; beat = 0; stall = 0; guard = 0;
    while (q.size() > 0 && guard < 400) begin
      chk("beat.valid", 64'(obs_valid), 64'd1);
      chk("beat.busy",  64'(obs_busy),  64'd1);
      chk("beat.idx",   64'(obs_idx),   64'(q[0]));
      chk("beat.last",  64'(obs_last),  64'(q.size() == 1));
      chk("beat.none",  64'(obs_none),  64'(empty));
      chk("beat.cnt",   64'(obs_cnt),   64'(acc));
      if (beat == stall_beat && stall < stall_len) begin
        r = 1'b0;
        stall++;
      end else if (rnd) begin
        r = 1'($urandom_range(0, 1));
      end else begin
        r = 1'b1;
      end
      o_ready = r;
      if (junk) begin
        ld  = 1'b1;
        din = ~d;
      end
      @(negedge clk);
      guard++;
      if (r) begin
        void'(q.pop_front());
        acc++;
        beat++;
      end
    end
    ld = 1'b0;
    o_ready = 1'b0;
    chk("scan.complete", 64'(q.size()), 64'd0);
    chk_idle("scan.end", acc);
  endtask

  initial begin
    logic [63:0] rv;
    bit          rm;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    chk_idle("reset64", 0);
    sel = 1'b1;
    chk_idle("reset48", 0);
    rst_n = 1'b1;

    // Basic MSB-first walk: 63, 5, 0
    run_scan(1'b0, 64'h8000_0000_0000_0021, 1'b0, -1, 0, 1'b0, 1'b0);
    // Backpressure at the second beat for three cycles
    run_scan(1'b0, 64'h8000_0000_0000_0021, 1'b0, 1, 3, 1'b0, 1'b0);
    // Empty vectors, direct and via find-zero
    run_scan(1'b0, 64'h0, 1'b0, -1, 0, 1'b0, 1'b0);
    run_scan(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, -1, 0, 1'b0, 1'b0);
    // 48-bit LSB-first find-zero: 1, 2
    run_scan(1'b1, 64'h0000_FFFF_FFFF_FFF9, 1'b1, -1, 0, 1'b0, 1'b0);
    run_scan(1'b1, 64'h0, 1'b1, -1, 0, 1'b0, 1'b0);
    // Loads presented during the scan (including the final handshake) are ignored
    run_scan(1'b0, 64'h0000_0000_0000_0021, 1'b0, 0, 2, 1'b0, 1'b1);
    run_scan(1'b1, 64'h0000_8000_0000_0001, 1'b0, -1, 0, 1'b0, 1'b1);

    // Abort coincident with ld and a handshake at beat 2
    @(negedge clk);
    sel = 1'b0; ld = 1'b1; din = 64'h8000_0000_0000_0021; mode = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    chk("abort.beat1", 64'(obs_idx), 64'd63);
    o_ready = 1'b1;
    @(negedge clk);
    chk("abort.beat2", 64'(obs_idx), 64'd5);
    chk("abort.cnt2",  64'(obs_cnt), 64'd1);
    abort = 1'b1; ld = 1'b1; din = 64'hF;
    @(negedge clk);
    abort = 1'b0; ld = 1'b0; o_ready = 1'b0;
    chk_idle("abort.after", 1);
    @(negedge clk);
    chk_idle("abort.noload", 1);

    // Asynchronous reset mid-scan, then a clean scan
    @(negedge clk);
    ld = 1'b1; din = 64'h0000_0000_0000_0F00; mode = 1'b0;
    @(negedge clk);
    ld = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk("rst.prebusy", 64'(obs_busy), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk_idle("rst.async", 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1'b0, 64'h0000_0000_0000_0F00, 1'b0, -1, 0, 1'b1, 1'b0);

    // Randomized loads on both instances with random backpressure
    for (int k = 0; k < 12; k++) begin
      rv = {$urandom, $urandom};
      if (k % 3 == 0) rv = rv & {$urandom, $urandom} & {$urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      run_scan(1'(k % 2), rv, rm, -1, 0, 1'b1, 1'(k % 4 == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
